// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH     default operand/result width
//   DIV_CNT_W     default iteration counter width (2**DIV_CNT_W > DIV_WIDTH)
//   div_state_t   controller state encoding
//   DBZ_QUOTIENT  quotient reported for a zero divisor (all ones, default width)
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH = 16;
   localparam int unsigned DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division trial subtract, evaluated WIDTH+1 bits wide so the
// top bit is the borrow.
//   shifted  partial remainder after the left shift (WIDTH bits)
//   divisor  latched divisor
//   diff     low WIDTH bits of shifted - divisor
//   borrow   1 when divisor > shifted (trial fails, restore)
module div_sub_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] shifted,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] trial;

   assign trial  = {1'b0, shifted} - {1'b0, divisor};
   assign diff   = trial[WIDTH-1:0];
   assign borrow = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only in IDLE or DONE
//   dividend      numerator, captured on the accepting edge
//   divisor       denominator, captured on the accepting edge
//   quotient      registered result, held until the next result load
//   remainder     registered result, held until the next result load
//   busy          high while iterating
//   done          one-cycle pulse when results become valid
//   div_by_zero   flag for the last result, valid with done and held after
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = DIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] shreg;     // dividend bits shift out the top, quotient bits in the bottom
   logic [WIDTH-1:0] dvsr;
   // Before the last iteration the partial remainder is below 2**(WIDTH-1)
   // (it never exceeds the dividend bits consumed so far), so its top bit is
   // not stored; only the final step can produce a full-width remainder.
   logic [WIDTH-2:0] prem;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             qbit;
   logic [WIDTH-1:0] prem_nxt;

   // Trial subtract for the current iteration
   assign shifted  = {prem, shreg[WIDTH-1]};
   assign qbit     = ~borrow;
   assign prem_nxt = borrow ? shifted : diff;

   div_sub_step #(
      .WIDTH (WIDTH)
   ) u_sub_step (
      .shifted (shifted),
      .divisor (dvsr),
      .diff    (diff),
      .borrow  (borrow)
   );

   // Controller, datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shreg       <= '0;
         dvsr        <= '0;
         prem        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (divisor != '0) begin
                     shreg <= dividend;
                     dvsr  <= divisor;
                     prem  <= '0;
                     cnt   <= CNT_W'(WIDTH - 1);
                     busy  <= 1'b1;
                     state <= RUN;
                  end else begin
                     // Zero divisor: report immediately, no iteration
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               shreg <= {shreg[WIDTH-2:0], qbit};
               prem  <= prem_nxt[WIDTH-2:0];
               cnt   <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  quotient    <= {shreg[WIDTH-2:0], qbit};
                  remainder   <= prem_nxt;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
